// File: rtl/cpu_step_controller.sv
// CPU step controller: debounced step button and run switch drive a
// STEP/RUN/HALT sequencer that emits one-clk cpu_en pulses, with a PC
// breakpoint that stops free-run mode.

// Two-flop synchronizer followed by a restart-on-bounce debouncer.
module cpu_step_sync_db #(
    parameter int   CYCLES  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);
    localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // metastability guard; resets to the inactive level of the input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= {2{RST_VAL}};
        else     sync <= {sync[0], raw};
    end

    // accept a new level only after CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            db  <= RST_VAL;
        end else if (sync[1] == db) begin
            cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
            cnt <= '0;
            db  <= sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module cpu_step_controller #(
    parameter int CLK_HZ          = 50000000,
    parameter int RUN_HZ          = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_step_n,
    input  logic        sw_run,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] cycle_count
);
    localparam int DIV   = CLK_HZ / RUN_HZ;
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t           st_q, st_d;
    logic             key_db, key_prev, run_db;
    logic             step_req, div_tc, en_d;
    logic [DIV_W-1:0] div;

    cpu_step_sync_db #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_key (
        .clk(clk), .rst(rst), .raw(key_step_n), .db(key_db)
    );
    cpu_step_sync_db #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_run (
        .clk(clk), .rst(rst), .raw(sw_run), .db(run_db)
    );

    // press edge of the debounced key; release produces nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_prev <= 1'b1;
        else     key_prev <= key_db;
    end
    assign step_req = key_prev & ~key_db;

    // run-rate divider; held at 0 outside RUN so every entry starts a full period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       div <= '0;
        else if (st_q != RUN || div_tc) div <= '0;
        else                           div <= div + 1'b1;
    end
    assign div_tc = (st_q == RUN) && (div == DIV_W'(DIV - 1));

    // state register plus registered pulse/halt outputs and pulse counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= IDLE;
            cpu_en      <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            st_q   <= st_d;
            cpu_en <= en_d;
            halted <= (st_d == HALT);
            if (cpu_en) cycle_count <= cycle_count + 32'd1;
        end
    end

    // next state and next cpu_en; the run switch outranks step requests
    always_comb begin
        st_d = st_q;
        en_d = 1'b0;
        case (st_q)
            IDLE: begin
                if (run_db) begin
                    st_d = RUN;
                end else if (step_req) begin
                    st_d = STEP;
                    en_d = 1'b1;   // registered, so high during STEP
                end
            end
            STEP: st_d = IDLE;
            RUN: begin
                if (!run_db) begin
                    st_d = IDLE;
                end else if (div_tc) begin
                    if (bp_en && pc == bp_addr) st_d = HALT;
                    else                        en_d = 1'b1;
                end
            end
            HALT: begin
                if (!run_db)       st_d = IDLE;
                else if (step_req) en_d = 1'b1;
            end
            default: st_d = IDLE;
        endcase
    end

    assign state = st_q;
endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed scenarios with randomized
// durations, checked cycle by cycle against a timing model derived from
// the input drive times (2 sync + 4 debounce clks, then the FSM reacts).
module tb_cpu_step_controller;
    localparam int PER  = 8;
    localparam int NONE = 1000000;
    localparam logic [1:0] S_IDLE = 2'b00, S_STEP = 2'b01, S_RUN = 2'b10, S_HALT = 2'b11;

    logic        clk = 1'b0, rst = 1'b1, key_step_n = 1'b1, sw_run = 1'b0, bp_en = 1'b0;
    logic [31:0] bp_addr = '0, pc = '0;
    logic        cpu_en, halted;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int          errors = 0, checks = 0, cyc = 0;
    logic [31:0] exp_cc = '0;
    logic        prev_en = 1'b0;

    cpu_step_controller #(.CLK_HZ(8), .RUN_HZ(1), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .key_step_n(key_step_n), .sw_run(sw_run),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
        .halted(halted), .state(state), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to the next negedge and compare all outputs with the model
    task automatic tick(input logic en, input logic [1:0] st, input logic hl);
        @(negedge clk);
        chk("cpu_en", 32'(cpu_en), 32'(en));
        chk("state", 32'(state), 32'(st));
        chk("halted", 32'(halted), 32'(hl));
        chk("cycle_count", cycle_count, exp_cc);
        chk("no_back_to_back", 32'(prev_en & cpu_en), 32'd0);
        prev_en = cpu_en;
        if (en) exp_cc = exp_cc + 32'd1;
    endtask

    // switch raised after edge r (dropped after edge f): RUN from edge r+7 to f+6,
    // pulses every PER clks after entry
    function automatic logic run_pulse(input int e, input int r, input int f);
        return (e > r + 7) && ((e - r - 7) % PER == 0) && (e <= f + 6);
    endfunction
    function automatic logic [1:0] run_state(input int e, input int r, input int f);
        return (e >= r + 7 && e <= f + 6) ? S_RUN : S_IDLE;
    endfunction

    initial begin
        int r, f, s, q, e, n, h, hp, halt_e;
        logic en;

        // reset state
        for (int i = 0; i < 3; i++) tick(1'b0, S_IDLE, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, S_IDLE, 1'b0);

        // single step: one pulse 7 clks after the press, STEP then IDLE
        s = cyc; key_step_n = 1'b0; h = 8 + int'($urandom_range(0, 4));
        for (int i = 0; i < h + 10; i++) begin
            e = cyc + 1;
            if (i == h) key_step_n = 1'b1;
            tick(e == s + 7, (e == s + 7) ? S_STEP : S_IDLE, 1'b0);
        end

        // bounce shorter than the debounce window never registers
        for (int rep = 0; rep < 3; rep++) begin
            hp = (rep == 0) ? 2 : int'($urandom_range(1, 3));
            for (int i = 0; i < 20; i++) begin
                if (i % hp == 0) key_step_n = ~key_step_n;
                tick(1'b0, S_IDLE, 1'b0);
            end
            key_step_n = 1'b1;
            for (int i = 0; i < 8; i++) tick(1'b0, S_IDLE, 1'b0);
        end

        // free run with a step press in the middle that must be ignored
        r = cyc; sw_run = 1'b1; n = 7 + 4 * PER + int'($urandom_range(0, 7));
        for (int i = 0; i < n; i++) begin
            e = cyc + 1;
            if (i == 10) key_step_n = 1'b0;
            if (i == 20) key_step_n = 1'b1;
            tick(run_pulse(e, r, NONE), run_state(e, r, NONE), 1'b0);
        end
        f = cyc; sw_run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            e = cyc + 1;
            tick(run_pulse(e, r, f), run_state(e, r, f), 1'b0);
        end

        // breakpoint at pc 0x0C: pulses at pc 0,4,8 then HALT at the 4th terminal count
        pc = '0; bp_en = 1'b1; bp_addr = 32'h0000_000C;
        r = cyc; sw_run = 1'b1; halt_e = r + 7 + 4 * PER;
        for (int i = 0; i < 45; i++) begin
            e = cyc + 1;
            en = (e < halt_e) && run_pulse(e, r, NONE);
            tick(en, (e >= halt_e) ? S_HALT : run_state(e, r, NONE), e >= halt_e);
            if (en) pc = pc + 32'd4;
        end
        s = cyc; key_step_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            e = cyc + 1;
            if (i == 9) key_step_n = 1'b1;
            tick(e == s + 7, S_HALT, 1'b1);
        end
        f = cyc; sw_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e = cyc + 1;
            tick(1'b0, (e <= f + 6) ? S_HALT : S_IDLE, e <= f + 6);
        end
        bp_en = 1'b0;

        // reset during a RUN pulse clears outputs without waiting for a clock
        r = cyc; sw_run = 1'b1;
        for (int i = 0; i < 15; i++) begin
            e = cyc + 1;
            tick(run_pulse(e, r, NONE), run_state(e, r, NONE), 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        exp_cc = '0; prev_en = 1'b0;
        for (int i = 0; i < 2; i++) tick(1'b0, S_IDLE, 1'b0);
        q = cyc; rst = 1'b0;
        n = 7 + 2 * PER + int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) begin
            e = cyc + 1;
            tick(run_pulse(e, q, NONE), run_state(e, q, NONE), 1'b0);
        end
        f = cyc; sw_run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            e = cyc + 1;
            tick(run_pulse(e, q, f), run_state(e, q, f), 1'b0);
        end

        // counter wrap: preload all-ones, one manual step rolls it to zero
        force dut.cycle_count = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count;
        exp_cc = 32'hFFFF_FFFF;
        s = cyc; key_step_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            e = cyc + 1;
            if (i == 9) key_step_n = 1'b1;
            tick(e == s + 7, (e == s + 7) ? S_STEP : S_IDLE, 1'b0);
        end
        chk("wrap", cycle_count, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
